ras_commit_stack: RTL and testbench
===================================

RAS_COMMIT_STACK -- requirements
Module: ras_commit_stack

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the number of committed stack entries (power of two).
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the stored return-address width.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 10, giving the stack pointer width; memory index = low log2(DEPTH) bits.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 commit_i  input  1  one committed action presented this cycle.
REQ-007 pop_i / push_i  input  1 each  kind of committed action.
REQ-008 data_i  input  WIDTH  return address of a committed push.
REQ-009 addr_i  input  ADDR_WIDTH  stack pointer after the action.
REQ-010 commit_ready_o  output  1  high when a commit is accepted this cycle.
REQ-011 rd_addr  input  ADDR_WIDTH; rd_data  output  WIDTH  lookup port.
REQ-012 top_addr_o  output  ADDR_WIDTH  committed top pointer.
REQ-013 count_o  output  $clog2(DEPTH+1)  valid entries; empty_o, full_o  output  1 each.
REQ-014 overflow_o / underflow_o  output  1 each  single-cycle event pulses.
REQ-015 flush_i  input  1  request a restore walk.
REQ-016 restore_valid_o  output  1; restore_ready_i  input  1; restore_addr_o  output  ADDR_WIDTH; restore_data_o  output  WIDTH  restore beat.
REQ-017 restore_done_o  output  1  single-cycle end-of-walk pulse; busy_o  output  1  FSM not IDLE.

Function
REQ-018 commit_ready_o SHALL equal (state == IDLE); a commit is accepted when commit_i && commit_ready_o; commit_i while not ready SHALL be dropped with no state change.
REQ-019 An accepted commit with push_i or pop_i SHALL set top_addr_o to addr_i next cycle; commit with neither SHALL change nothing.
REQ-020 Accepted push SHALL write data_i to mem[addr_i mod DEPTH].
REQ-021 Push only: count+1; if count == DEPTH, count holds and overflow_o pulses next cycle (oldest entry overwritten by wrap).
REQ-022 Pop only: count-1; if count == 0, count holds at 0 and underflow_o pulses next cycle.
REQ-023 Push and pop together SHALL act as replace: write performed, count unchanged, no pulses.
REQ-024 empty_o = (count == 0); full_o = (count == DEPTH); both combinational from count.
REQ-025 rd_data SHALL be registered, latency 1, rd_data = mem[rd_addr mod DEPTH]; same-cycle accepted push to same index SHALL return the new data (write-first).
REQ-026 FSM states: IDLE, LOAD, SEND, DONE.
REQ-027 IDLE && flush_i: latch ptr = top_addr_o, rem = count_o; go LOAD if rem != 0, else DONE.
REQ-028 LOAD: read mem[ptr mod DEPTH] on internal port; next state SEND; restore_valid_o low.
REQ-029 SEND: restore_valid_o high, restore_addr_o = ptr, restore_data_o = loaded data, all stable until restore_ready_i.
REQ-030 SEND && restore_ready_i: rem-1; if rem was 1 go DONE, else ptr = ptr-1 modulo 2^ADDR_WIDTH and go LOAD.
REQ-031 DONE: restore_done_o high one cycle, then IDLE.
REQ-032 flush_i outside IDLE SHALL be ignored; commits during a walk are refused per REQ-018.
REQ-033 Restore walk SHALL not modify mem, count_o or top_addr_o.

Reset
REQ-034 While reset_n low at clk edge: state IDLE, count 0, top_addr_o 0, rd_data 0, all restore outputs and pulses 0; mem contents not reset.
REQ-035 Reset during a walk SHALL abort it without restore_done_o.

Verification
REQ-036 Reset, push 0xA0/addr 1, push 0xB0/addr 2 -> count 2, top_addr 2, rd_addr 2 gives 0xB0 one cycle later.
REQ-037 17 pushes into DEPTH 16 -> count 16, full_o 1, overflow_o single pulse after 17th; pop on empty -> underflow_o pulse, count 0.
REQ-038 Push 0xC0 to addr 3 while rd_addr 3 same cycle -> rd_data 0xC0 next cycle; push+pop same cycle -> count unchanged.
REQ-039 count 3, top 5, flush_i, ready held low 4 cycles then high -> beats addr 5,4,3 with stored data, done pulse once, busy_o low afterward; commit_i during walk dropped.
REQ-040 flush with count 0 -> no restore_valid_o, restore_done_o two cycles after flush; reset_n low mid-walk -> IDLE, no done pulse.

Source files
------------

// File: rtl/ras_commit_stack.sv
// ras_commit_stack
// ----------------
// Committed return-address stack. It accepts one committed push/pop/replace per
// cycle, keeps the committed top pointer and the valid-entry count, and serves a
// registered lookup port. On a flush request it walks the committed entries from
// the top downwards and offers each one as a restore beat (valid/ready). The
// restore walk never modifies the stack.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   commit_i              committed action presented this cycle
//   push_i, pop_i         kind of action (both = replace)
//   data_i                return address of a committed push
//   addr_i                stack pointer after the action
//   commit_ready_o        commit accepted this cycle (FSM idle)
//   rd_addr, rd_data      lookup port, one-cycle latency, write-first
//   top_addr_o            committed top pointer
//   count_o               number of valid entries
//   empty_o, full_o       count == 0 / count == DEPTH
//   overflow_o            one-cycle pulse: push while full
//   underflow_o           one-cycle pulse: pop while empty
//   flush_i               start a restore walk (ignored unless idle)
//   restore_valid_o       restore beat valid
//   restore_ready_i       restore beat consumed
//   restore_addr_o        pointer of the beat
//   restore_data_o        stored return address of the beat
//   restore_done_o        one-cycle pulse at the end of a walk
//   busy_o                walk in progress (FSM not idle)
module ras_commit_stack #(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         commit_i,
    input  logic                         pop_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic [ADDR_WIDTH-1:0]        addr_i,
    output logic                         commit_ready_o,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic [WIDTH-1:0]             rd_data,
    output logic [ADDR_WIDTH-1:0]        top_addr_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic                         overflow_o,
    output logic                         underflow_o,
    input  logic                         flush_i,
    output logic                         restore_valid_o,
    input  logic                         restore_ready_i,
    output logic [ADDR_WIDTH-1:0]        restore_addr_o,
    output logic [WIDTH-1:0]             restore_data_o,
    output logic                         restore_done_o,
    output logic                         busy_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [WIDTH-1:0]      r_rd_data;
    logic [WIDTH-1:0]      r_load_data;
    logic [ADDR_WIDTH-1:0] r_top;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      r_rem;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [IDX_W-1:0]      w_ptr_idx;
    logic                  w_unused_rd_addr;

    // Commits are only taken while idle, so a walk never races a memory write.
    assign w_accept  = reset_n && commit_i && (r_state == S_IDLE);
    assign w_push    = w_accept && push_i;
    assign w_pop     = w_accept && pop_i;
    assign w_wr_idx  = addr_i[IDX_W-1:0];
    assign w_rd_idx  = rd_addr[IDX_W-1:0];
    assign w_ptr_idx = r_ptr[IDX_W-1:0];

    // Only the low index bits of the lookup address select an entry.
    assign w_unused_rd_addr = ^rd_addr;

    // NOTE: the storage array has no reset; only the control state is cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_idx] <= data_i;
        end
    end

    // Lookup port: a push to the same index in the same cycle wins (write-first).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else if (w_push && (w_wr_idx == w_rd_idx)) begin
            r_rd_data <= data_i;
        end else begin
            r_rd_data <= r_mem[w_rd_idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_top       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            if (w_push || w_pop) begin
                r_top <= addr_i;
            end
            // Push+pop together is a replace: count and pulses untouched.
            if (w_push && !w_pop) begin
                if (r_count == CNT_W'(DEPTH)) begin
                    r_overflow <= 1'b1;   // oldest entry lost through wrap
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else if (w_pop && !w_push) begin
                if (r_count == '0) begin
                    r_underflow <= 1'b1;
                end else begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

    // Restore walk state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the next-state default is assigned first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (flush_i) begin
                    w_state_nxt = (r_count != '0) ? S_LOAD : S_DONE;
                end
            end
            S_LOAD: w_state_nxt = S_SEND;
            S_SEND: begin
                if (restore_ready_i) begin
                    w_state_nxt = (r_rem == CNT_W'(1)) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Walk datapath: pointer, remaining count and the loaded entry.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr       <= '0;
            r_rem       <= '0;
            r_load_data <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (flush_i) begin
                        r_ptr <= r_top;
                        r_rem <= r_count;
                    end
                end
                S_LOAD: r_load_data <= r_mem[w_ptr_idx];
                S_SEND: begin
                    if (restore_ready_i) begin
                        r_rem <= r_rem - CNT_W'(1);
                        if (r_rem != CNT_W'(1)) begin
                            r_ptr <= r_ptr - ADDR_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign commit_ready_o  = (r_state == S_IDLE);
    assign busy_o          = (r_state != S_IDLE);
    assign restore_valid_o = (r_state == S_SEND);
    assign restore_done_o  = (r_state == S_DONE);
    // Beat fields are zero outside a beat so idle outputs stay quiet.
    assign restore_addr_o  = restore_valid_o ? r_ptr : '0;
    assign restore_data_o  = restore_valid_o ? r_load_data : '0;

    assign rd_data     = r_rd_data;
    assign top_addr_o  = r_top;
    assign count_o     = r_count;
    assign empty_o     = (r_count == '0);
    assign full_o      = (r_count == CNT_W'(DEPTH));
    assign overflow_o  = r_overflow;
    assign underflow_o = r_underflow;

endmodule

// File: tb/tb_ras_commit_stack.sv
// tb_ras_commit_stack
// -------------------
// Bench for ras_commit_stack. Stimulus is issued on the falling edge; for each
// cycle a reference model (plain arrays and integers) computes the expected
// post-edge state and pushes it on a queue. Flush requests push the list of
// expected restore beats. A separate monitor samples the DUT one time unit after
// each falling edge, pops expectations and compares.
module tb_ras_commit_stack;

    localparam int DEPTH = 16;
    localparam int WIDTH = 32;
    localparam int AW    = 10;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int AMASK = (1 << AW) - 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             commit_i = 1'b0;
    logic             pop_i = 1'b0;
    logic             push_i = 1'b0;
    logic [WIDTH-1:0] data_i = '0;
    logic [AW-1:0]    addr_i = '0;
    logic             commit_ready_o;
    logic [AW-1:0]    rd_addr = '0;
    logic [WIDTH-1:0] rd_data;
    logic [AW-1:0]    top_addr_o;
    logic [CW-1:0]    count_o;
    logic             empty_o;
    logic             full_o;
    logic             overflow_o;
    logic             underflow_o;
    logic             flush_i = 1'b0;
    logic             restore_valid_o;
    logic             restore_ready_i = 1'b0;
    logic [AW-1:0]    restore_addr_o;
    logic [WIDTH-1:0] restore_data_o;
    logic             restore_done_o;
    logic             busy_o;

    always #5 clk = ~clk;

    ras_commit_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .commit_i        (commit_i),
        .pop_i           (pop_i),
        .push_i          (push_i),
        .data_i          (data_i),
        .addr_i          (addr_i),
        .commit_ready_o  (commit_ready_o),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .top_addr_o      (top_addr_o),
        .count_o         (count_o),
        .empty_o         (empty_o),
        .full_o          (full_o),
        .overflow_o      (overflow_o),
        .underflow_o     (underflow_o),
        .flush_i         (flush_i),
        .restore_valid_o (restore_valid_o),
        .restore_ready_i (restore_ready_i),
        .restore_addr_o  (restore_addr_o),
        .restore_data_o  (restore_data_o),
        .restore_done_o  (restore_done_o),
        .busy_o          (busy_o)
    );

    typedef struct {
        int               count;
        int               top;
        bit               ovf;
        bit               unf;
        bit               rd_chk;
        logic [WIDTH-1:0] rd;
        bit               idle_chk;
    } exp_t;

    typedef struct {
        int               addr;
        logic [WIDTH-1:0] data;
        bit               dchk;
    } beat_t;

    exp_t  exp_q[$];
    beat_t beat_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;

    // Reference model: stack contents as a plain array, count and top as integers.
    logic [WIDTH-1:0] m_mem [DEPTH];
    bit               m_vld [DEPTH];
    int               m_count = 0;
    int               m_top = 0;
    bit               walk_active = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle of stimulus plus the model's view of the resulting state.
    task automatic cycle(input bit rst, input bit c, input bit pu, input bit po,
                         input logic [WIDTH-1:0] d, input int a, input int ra,
                         input bit fl, input bit rdy, input bit ichk);
        exp_t e;
        bit   acc;
        int   idx;
        @(negedge clk);
        reset_n = rst; commit_i = c; push_i = pu; pop_i = po; data_i = d;
        addr_i = AW'(a); rd_addr = AW'(ra); flush_i = fl; restore_ready_i = rdy;
        e.ovf = 1'b0;
        e.unf = 1'b0;
        e.idle_chk = ichk;
        if (!rst) begin
            m_count = 0;
            m_top = 0;
            walk_active = 1'b0;
            e.rd_chk = 1'b1;
            e.rd = '0;
        end else begin
            acc = c && !walk_active;
            if (fl && !walk_active) begin
                walk_active = 1'b1;
                for (int i = 0; i < m_count; i++) begin
                    beat_t b;
                    b.addr = (m_top - i) & AMASK;
                    b.data = m_mem[b.addr % DEPTH];
                    b.dchk = m_vld[b.addr % DEPTH];
                    beat_q.push_back(b);
                end
            end
            if (acc && pu) begin
                m_mem[a % DEPTH] = d;
                m_vld[a % DEPTH] = 1'b1;
            end
            if (acc && (pu || po)) m_top = a & AMASK;
            if (acc && pu && !po) begin
                if (m_count == DEPTH) e.ovf = 1'b1;
                else m_count++;
            end else if (acc && po && !pu) begin
                if (m_count == 0) e.unf = 1'b1;
                else m_count--;
            end
            idx = (ra & AMASK) % DEPTH;
            e.rd_chk = m_vld[idx];
            e.rd = m_mem[idx];
        end
        @(posedge clk);
        if (!rst) beat_q.delete();
        e.count = m_count;
        e.top = m_top;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int ra);
        cycle(1, 0, 0, 0, '0, 0, ra, 0, 0, 1);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0, 0, 0, 0, 0, 1);
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input int a, input int ra);
        cycle(1, 1, 1, 0, d, a, ra, 0, 0, 1);
    endtask

    task automatic pop(input int a);
        cycle(1, 1, 0, 1, '0, a, 0, 0, 0, 1);
    endtask

    // Flush, then drive ready (low for hold_low cycles, then high or random)
    // until the done pulse, optionally throwing commits at the busy block.
    task automatic do_walk(input int hold_low, input bit rand_ready,
                           input bit with_commits, output int iters);
        int d0;
        bit rdy;
        bit c;
        cycle(1, 0, 0, 0, '0, 0, 0, 1, 0, 0);
        d0 = done_seen;
        iters = 0;
        while (done_seen == d0 && iters < 300) begin
            rdy = (iters < hold_low) ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            c = with_commits && (beat_q.size() > 0) && 1'($urandom_range(0, 1));
            cycle(1, c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                  $urandom_range(0, AMASK), 0, 0, rdy, 0);
            iters++;
        end
        check("walk_timeout", 64'(iters < 300), 64'd1);
        check("beats_left", 64'(beat_q.size()), 64'd0);
        walk_active = 1'b0;
        idle(0);
        idle(0);
        check("done_pulses", 64'(done_seen - d0), 64'd1);
    endtask

    // Monitor: compares the state left by the previous rising edge.
    initial begin
        exp_t  e;
        beat_t b;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("count", 64'(count_o), 64'(e.count));
                check("top_addr", 64'(top_addr_o), 64'(e.top));
                check("empty", 64'(empty_o), 64'(e.count == 0));
                check("full", 64'(full_o), 64'(e.count == DEPTH));
                check("overflow", 64'(overflow_o), 64'(e.ovf));
                check("underflow", 64'(underflow_o), 64'(e.unf));
                if (e.rd_chk) check("rd_data", 64'(rd_data), 64'(e.rd));
                if (e.idle_chk) begin
                    check("busy_idle", 64'(busy_o), 64'd0);
                    check("commit_ready_idle", 64'(commit_ready_o), 64'd1);
                end
            end
            if (restore_done_o) done_seen++;
            if (restore_valid_o) begin
                check("beat_expected", 64'(beat_q.size() > 0), 64'd1);
                if (restore_ready_i && beat_q.size() > 0) begin
                    b = beat_q.pop_front();
                    check("restore_addr", 64'(restore_addr_o), 64'(b.addr));
                    if (b.dchk) check("restore_data", 64'(restore_data_o), 64'(b.data));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end");
        $fatal(1, "watchdog");
    end

    initial begin
        int iters;
        int d0;
        int r;

        do_reset(3);

        // Two pushes, then look up the top entry.
        push(32'hA0, 1, 0);
        push(32'hB0, 2, 0);
        idle(2);
        idle(1);

        // Seventeen pushes into a 16-deep stack, then drain past empty.
        do_reset(1);
        for (int i = 0; i < 17; i++) push(32'h100 + i, i + 1, i);
        for (int i = 0; i < 17; i++) pop(16 - i);
        pop(0);
        idle(0);

        // Write-first lookup and replace.
        push(32'hC0, 3, 3);
        idle(3);
        push(32'h11, 4, 0);
        cycle(1, 1, 1, 1, 32'h22, 4, 4, 0, 0, 1);
        idle(4);

        // Walk of three entries with ready held low first, commits thrown at it.
        do_reset(1);
        push(32'h33, 3, 0);
        push(32'h44, 4, 0);
        push(32'h55, 5, 0);
        do_walk(4, 1'b0, 1'b1, iters);
        idle(5);

        // Empty walk: done one cycle after the flush takes effect, no beats.
        do_reset(1);
        do_walk(0, 1'b0, 1'b0, iters);
        check("empty_walk_len", 64'(iters), 64'd1);

        // Reset in the middle of a walk aborts it silently.
        push(32'h66, 6, 0);
        push(32'h77, 7, 0);
        cycle(1, 0, 0, 0, '0, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, '0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, '0, 0, 0, 0, 0, 0);
        d0 = done_seen;
        do_reset(1);
        idle(0);
        idle(0);
        check("abort_no_done", 64'(done_seen - d0), 64'd0);

        // Randomized traffic with occasional walks.
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_walk($urandom_range(0, 3), 1'b1, 1'b1, iters);
            end else begin
                cycle(1, 1'(r < 80), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom, $urandom_range(0, AMASK), $urandom_range(0, AMASK), 0, 0, 1);
            end
        end
        idle(0);
        idle(0);
        @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
